pipe_stage_skid: RTL

Parametrised pipeline stage register with a valid/ready handshake, an optional skid entry, stall and flush controls, and a saturating stall-bubble counter. It replaces fixed per-stage latch banks such as ID/EX with one reusable block. The payload is split into a control field, zeroed on flush or when the stage is empty, and a data field. It sits between any two pipeline stages of the CPU and is driven by the hazard unit's stall and flush lines.

---
 rtl/pipe_stage_skid.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Reusable pipeline stage register with a valid/ready handshake, an optional
// skid entry, hazard stall/flush controls and a saturating stall-bubble
// counter. The payload is split into a control field (zeroed on flush and
// masked to zero on the output while the stage is empty) and a data field.
// All state updates on the falling edge of clk, like the rest of the
// pipeline registers.
//
// Parameters
//   CTRL_W  width of the control payload
//   DATA_W  width of the data payload
//   SKID    1: two entries (main + skid), in_ready is registered-only
//           0: one entry, in_ready passes out_ready through combinationally
//   CNT_W   width of the bubble counter
//
// Ports
//   clk         clock (falling-edge active)
//   rst         synchronous active-high reset
//   in_valid    upstream beat present
//   in_ready    stage accepts the beat this cycle
//   in_ctrl     upstream control payload
//   in_data     upstream data payload
//   stall       hold contents, present a bubble downstream
//   flush       discard held and incoming beats
//   out_valid   downstream beat present
//   out_ready   downstream accepts
//   out_ctrl    main-entry control, zero when empty
//   out_data    main-entry data
//   occupancy   entries held (0..2)
//   bubble_cnt  saturating count of stalled cycles while occupied
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int CTRL_W = 24,
    parameter int DATA_W = 160,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    occ_t              state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d;

    logic in_fire;
    logic out_fire;
    logic has_room;

    // With a skid entry, readiness depends only on registered occupancy so no
    // combinational out_ready -> in_ready path exists. Without it, a full
    // stage can still accept when the held beat leaves in the same cycle.
    always_comb begin
        if (SKID != 0) begin
            has_room = (state_q != TWO);
        end else begin
            has_room = (state_q == EMPTY) || out_ready;
        end
    end

    assign in_ready  = !stall && !flush && has_room;
    assign out_valid = (state_q != EMPTY) && !stall;
    assign out_ctrl  = (state_q != EMPTY) ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign bubble_cnt = bubble_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Next-state: flush beats stall beats normal handshaking.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        bubble_d    = bubble_q;

        if (flush) begin
            // Data fields are left as-is; only control is cleared so a
            // discarded beat can never assert side effects downstream.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else if (stall) begin
            if (state_q != EMPTY) begin
                bubble_d = sat_inc(bubble_q);
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry; a single-entry
                        // stage accepts in ONE only when out_fire is set.
                        if (SKID != 0) begin
                            state_d     = TWO;
                            skid_ctrl_d = in_ctrl;
                            skid_data_d = in_data;
                        end
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            bubble_q    <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            bubble_q    <= bubble_d;
        end
    end

endmodule
